fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data word width (matches FIFO read-port width).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, rclk cycles per serial bit; legal range 2..65535.
REQ-003 SHALL have parameter PARITY, default 0, 0 = none, 1 = even, 2 = odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-005 SHALL have port rclk, input, 1, the only clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port rempty, input, 1, FIFO read-side empty flag.
REQ-008 SHALL have port rdata, input, DSIZE, FIFO head word; first-word-fall-through, valid whenever rempty=0.
REQ-009 SHALL have port rinc, output, 1, FIFO pop strobe; one-cycle pulse.
REQ-010 SHALL have port tx_en, input, 1, permits new frames to start.
REQ-011 SHALL have port txd, output, 1, serial line; idle high.
REQ-012 SHALL have port busy, output, 1, high while a frame is on the line.
REQ-013 SHALL have port frames_sent, output, 16, count of completed frames.

Function
REQ-014 SHALL implement an FSM with states IDLE, START, DATA, PAR, STOP.
REQ-015 IDLE: txd=1, busy=0; if tx_en=1 and rempty=0, SHALL capture rdata into the shift register, assert rinc for exactly that cycle, and enter START next cycle.
REQ-016 SHALL NOT assert rinc when rempty=1, under any condition.
REQ-017 Bit timing: every line bit (start, data, parity, stop) SHALL last exactly CLKS_PER_BIT cycles, timed by a bit-cycle counter that restarts at each bit boundary.
REQ-018 START: txd=0 for one bit time, then DATA.
REQ-019 DATA: SHALL shift out DSIZE bits LSB first, with a bit index counter 0..DSIZE-1; after the last bit go to PAR if PARITY!=0, else STOP.
REQ-020 PAR: txd = XOR of the captured word (even), or its inverse (odd), for one bit time.
REQ-021 STOP: txd=1 for STOP_BITS bit times.
REQ-022 busy SHALL be 1 from the first START cycle through the last STOP cycle inclusive.
REQ-023 frames_sent SHALL increment by 1 on the last STOP cycle, and wrap from 0xFFFF to 0x0000.
REQ-024 Back-to-back: on the last STOP cycle, if tx_en=1 and rempty=0, SHALL capture rdata and pulse rinc in that cycle, then enter START next cycle with no idle gap; otherwise SHALL enter IDLE.
REQ-025 tx_en deasserted mid-frame SHALL NOT abort the frame; it only blocks the next capture.
REQ-026 The captured word SHALL be held internally; changes on rdata/rempty after capture SHALL NOT affect the frame in flight.
REQ-027 Total frame length SHALL be (1 + DSIZE + (PARITY?1:0) + STOP_BITS) * CLKS_PER_BIT cycles.

Reset
REQ-028 rst_n=0 SHALL immediately force: state=IDLE, txd=1, rinc=0, busy=0, frames_sent=0, and all counters and the shift register to 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame, without incrementing frames_sent.
REQ-030 After rst_n rises, the first capture SHALL occur no earlier than the first rclk edge at which IDLE conditions hold.

Verification
REQ-031 Single word: CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1, FIFO holds 0xA5 -> one rinc pulse; txd = 0,1,0,1,0,0,1,0,1,1, each for 4 cycles (40 cycles total); frames_sent=1; then IDLE.
REQ-032 Back-to-back: FIFO holds 0x01 and 0x02 -> second rinc on cycle 40 of frame 1; frame-2 start bit begins on the next cycle; busy stays high for 80 cycles; frames_sent=2.
REQ-033 Empty FIFO: rempty=1 with tx_en=1 for 100 cycles -> rinc never asserted; txd=1, busy=0 throughout.
REQ-034 Parity: PARITY=1, data 0x07 -> parity bit 1; PARITY=2, data 0x07 -> parity bit 0; frame length 44 cycles at CLKS_PER_BIT=4.
REQ-035 tx_en drop: deassert tx_en during DATA of a frame with 3 words queued -> current frame completes; no rinc while tx_en=0; transmission resumes within 1 cycle of tx_en=1.
REQ-036 Reset mid-frame: pull rst_n low during DATA -> txd=1 and busy=0 asynchronously; frames_sent=0; the next word is sent normally after release.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains words from a first-word-fall-through FIFO read port
// and sends each one as an asynchronous serial frame:
// start bit, DSIZE data bits LSB first, optional parity bit, 1 or 2 stop bits.
module fifo_uart_tx #(
  parameter int DSIZE        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,   // 0 none, 1 even, 2 odd
  parameter int STOP_BITS    = 1    // 1 or 2
) (
  input  logic             rclk,
  input  logic             rst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             tx_en,
  output logic             txd,
  output logic             busy,
  output logic [15:0]      frames_sent
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DSIZE > 1) ? $clog2(DSIZE) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t           state;
  logic [CW-1:0]    bit_cnt;    // cycles elapsed within the current line bit
  logic [IW-1:0]    bit_idx;    // data bit being sent
  logic             stop_idx;   // stop bit being sent
  logic [DSIZE-1:0] shift_reg;  // captured word, shifted right per data bit
  logic             par_bit;    // parity of the captured word, fixed at capture
  logic [DSIZE-1:0] shift_nxt;
  logic             bit_end;
  logic             last_stop;
  logic             load;

  assign shift_nxt = shift_reg >> 1;
  assign bit_end   = (bit_cnt == CW'(CLKS_PER_BIT - 1));
  assign last_stop = (state == STOP) && bit_end && (stop_idx == 1'(STOP_BITS - 1));

  // The pop strobe is decoded combinationally so it lands in the very cycle the
  // head word is captured; a registered strobe would pop one cycle late.
  // Gating with rst_n keeps the FIFO untouched while reset is held.
  assign load = rst_n && tx_en && !rempty && ((state == IDLE) || last_stop);
  assign rinc = load;

  // Frame sequencer: state, bit timing, shift register and registered line outputs.
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      shift_reg   <= '0;
      par_bit     <= 1'b0;
      txd         <= 1'b1;
      busy        <= 1'b0;
      frames_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (load) begin
            shift_reg <= rdata;
            par_bit   <= (^rdata) ^ (PARITY == 2);
            bit_idx   <= '0;
            state     <= START;
            txd       <= 1'b0;
            busy      <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
            txd     <= shift_reg[0];
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == IW'(DSIZE - 1)) begin
              if (PARITY != 0) begin
                state <= PAR;
                txd   <= par_bit;
              end else begin
                state    <= STOP;
                stop_idx <= 1'b0;
                txd      <= 1'b1;
              end
            end else begin
              bit_idx   <= bit_idx + IW'(1);
              shift_reg <= shift_nxt;
              txd       <= shift_nxt[0];
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end

        PAR: begin
          if (bit_end) begin
            bit_cnt  <= '0;
            state    <= STOP;
            stop_idx <= 1'b0;
            txd      <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (last_stop) begin
              frames_sent <= frames_sent + 16'd1;
              if (load) begin
                // Back-to-back: next frame starts with no idle gap.
                shift_reg <= rdata;
                par_bit   <= (^rdata) ^ (PARITY == 2);
                bit_idx   <= '0;
                state     <= START;
                txd       <= 1'b0;
              end else begin
                state <= IDLE;
                txd   <= 1'b1;
                busy  <= 1'b0;
              end
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: three transmitter configurations, each fed by a small
// FIFO model; every frame is compared cycle by cycle against a line waveform
// built from the word, parity mode and stop-bit count.
module tb_fifo_uart_tx;

  localparam int ND = 3;
  localparam int CPB  [ND] = '{4, 4, 5};
  localparam int PARS [ND] = '{0, 1, 2};
  localparam int STBS [ND] = '{1, 1, 2};

  logic          rclk = 1'b0;
  logic          rst_n;
  logic [ND-1:0] rempty_v, rinc_v, tx_en_v, txd_v, busy_v;
  logic [7:0]    rdata_v [ND];
  logic [15:0]   fs0, fs1, fs2;

  // FIFO model: stimulus owns wr_ptr/mem, the pop process owns rd_ptr.
  logic [7:0]  mem    [ND][64];
  int          wr_ptr [ND];
  int          rd_ptr [ND] = '{0, 0, 0};
  int          viol = 0;

  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_idx [ND];
  logic [15:0] exp_fs  [ND];

  always #5 rclk = ~rclk;

  for (genvar g = 0; g < ND; g++) begin : g_fifo
    assign rempty_v[g] = (wr_ptr[g] == rd_ptr[g]);
    assign rdata_v[g]  = mem[g][rd_ptr[g] % 64];
  end

  // Pop on strobe; flag any strobe seen with an empty FIFO or tx_en low.
  always @(posedge rclk) begin
    for (int d = 0; d < ND; d++) begin
      if (rinc_v[d]) begin
        rd_ptr[d] <= rd_ptr[d] + 1;
        if (rempty_v[d] || !tx_en_v[d]) viol <= viol + 1;
      end
    end
  end

  fifo_uart_tx #(.DSIZE(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_d0 (
    .rclk(rclk), .rst_n(rst_n), .rempty(rempty_v[0]), .rdata(rdata_v[0]),
    .rinc(rinc_v[0]), .tx_en(tx_en_v[0]), .txd(txd_v[0]), .busy(busy_v[0]),
    .frames_sent(fs0));

  fifo_uart_tx #(.DSIZE(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_d1 (
    .rclk(rclk), .rst_n(rst_n), .rempty(rempty_v[1]), .rdata(rdata_v[1]),
    .rinc(rinc_v[1]), .tx_en(tx_en_v[1]), .txd(txd_v[1]), .busy(busy_v[1]),
    .frames_sent(fs1));

  fifo_uart_tx #(.DSIZE(8), .CLKS_PER_BIT(5), .PARITY(2), .STOP_BITS(2)) u_d2 (
    .rclk(rclk), .rst_n(rst_n), .rempty(rempty_v[2]), .rdata(rdata_v[2]),
    .rinc(rinc_v[2]), .tx_en(tx_en_v[2]), .txd(txd_v[2]), .busy(busy_v[2]),
    .frames_sent(fs2));

  function automatic logic [15:0] get_fs(input int d);
    case (d)
      0:       return fs0;
      1:       return fs1;
      default: return fs2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge rclk);
    #1;
  endtask

  task automatic push(input int d, input logic [7:0] w);
    mem[d][wr_ptr[d] % 64] = w;
    wr_ptr[d]++;
  endtask

  task automatic wait_rinc(input int d, input int budget, output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < budget) begin
      @(negedge rclk);
      if (rinc_v[d]) ok = 1'b1;
      i++;
    end
    check($sformatf("d%0d capture within %0d cycles", d, budget), ok, 1);
  endtask

  // Follows nframes frames on DUT d; the first one must be captured from IDLE
  // within 'budget' cycles, later ones either chain or are captured from IDLE.
  task automatic check_stream(input int d, input int nframes, input int budget);
    bit         chained;
    bit         ok;
    bit         nxt;
    logic [7:0] w;
    logic       bits [16];
    int         nb, len, c;
    c       = CPB[d];
    chained = 1'b0;
    nxt     = 1'b0;
    for (int f = 0; f < nframes; f++) begin
      if (!chained) begin
        wait_rinc(d, (f == 0) ? budget : 2000, ok);
        if (!ok) return;
        check($sformatf("d%0d idle txd at capture", d), txd_v[d], 1);
        check($sformatf("d%0d idle busy at capture", d), busy_v[d], 0);
      end
      w = mem[d][exp_idx[d] % 64];
      exp_idx[d]++;
      nb = 0;
      bits[nb++] = 1'b0;
      for (int k = 0; k < 8; k++) bits[nb++] = w[k];
      if (PARS[d] != 0) bits[nb++] = (^w) ^ (PARS[d] == 2);
      for (int s = 0; s < STBS[d]; s++) bits[nb++] = 1'b1;
      len = nb * c;
      for (int i = 0; i < len; i++) begin
        @(negedge rclk);
        if (i == 0) check($sformatf("d%0d frames_sent at frame start", d), get_fs(d), exp_fs[d]);
        check($sformatf("d%0d w=%02h txd cycle %0d", d, w, i), txd_v[d], bits[i / c]);
        check($sformatf("d%0d w=%02h busy cycle %0d", d, w, i), busy_v[d], 1);
        nxt = tx_en_v[d] && (wr_ptr[d] != rd_ptr[d]);
        check($sformatf("d%0d w=%02h rinc cycle %0d", d, w, i), rinc_v[d],
              (i == len - 1) ? nxt : 1'b0);
      end
      exp_fs[d]++;
      chained = nxt;
      if (!chained) begin
        @(negedge rclk);
        check($sformatf("d%0d txd after frame", d), txd_v[d], 1);
        check($sformatf("d%0d busy after frame", d), busy_v[d], 0);
        check($sformatf("d%0d frames_sent after frame", d), get_fs(d), exp_fs[d]);
      end
    end
  endtask

  initial begin
    bit ok;
    int bad;
    for (int d = 0; d < ND; d++) begin
      wr_ptr[d]  = 0;
      exp_idx[d] = 0;
      exp_fs[d]  = 16'd0;
    end
    rst_n   = 1'b0;
    tx_en_v = '1;

    // Reset holds everything idle even with data waiting and tx_en high.
    after_edge();
    push(0, 8'hA5);
    #1;
    check("reset rinc", rinc_v, 3'b000);
    check("reset txd", txd_v, 3'b111);
    check("reset busy", busy_v, 3'b000);
    check("reset fs0", fs0, 0);
    check("reset fs1", fs1, 0);
    check("reset fs2", fs2, 0);

    // Single word 0xA5, captured on the first idle edge after release.
    after_edge();
    rst_n = 1'b1;
    check_stream(0, 1, 1);

    // Empty FIFO: no pops, line idle.
    bad = 0;
    repeat (100) begin
      @(negedge rclk);
      if (txd_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || rinc_v[0] !== 1'b0) bad++;
    end
    check("empty fifo idle cycles bad", bad, 0);

    // Back-to-back 0x01, 0x02.
    after_edge();
    push(0, 8'h01);
    push(0, 8'h02);
    check_stream(0, 2, 1);

    // tx_en dropped mid-frame with three words queued.
    after_edge();
    for (int k = 0; k < 3; k++) push(0, 8'($urandom));
    fork
      check_stream(0, 1, 1);
      begin
        repeat (12) @(posedge rclk);
        #2;
        tx_en_v[0] = 1'b0;
      end
    join
    bad = 0;
    repeat (20) begin
      @(negedge rclk);
      if (rinc_v[0] !== 1'b0 || txd_v[0] !== 1'b1) bad++;
    end
    check("tx_en low hold bad cycles", bad, 0);
    after_edge();
    tx_en_v[0] = 1'b1;
    check_stream(0, 2, 1);

    // Reset mid-frame during DATA.
    after_edge();
    push(0, 8'($urandom));
    wait_rinc(0, 1, ok);
    exp_idx[0]++;
    repeat (10) @(posedge rclk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midframe reset txd", txd_v[0], 1);
    check("midframe reset busy", busy_v[0], 0);
    check("midframe reset fs0", fs0, 0);
    exp_fs[0] = 16'd0;
    after_edge();
    rst_n = 1'b1;
    push(0, 8'($urandom));
    check_stream(0, 1, 1);

    // Randomised stream of chained frames.
    after_edge();
    for (int k = 0; k < 8; k++) push(0, 8'($urandom));
    check_stream(0, 8, 1);

    // Even parity, then odd parity with two stop bits.
    after_edge();
    push(1, 8'h07);
    for (int k = 0; k < 3; k++) push(1, 8'($urandom));
    check_stream(1, 4, 1);
    after_edge();
    push(2, 8'h07);
    for (int k = 0; k < 3; k++) push(2, 8'($urandom));
    check_stream(2, 4, 1);

    repeat (5) @(negedge rclk);
    check("rinc protocol violations", viol, 0);
    for (int d = 0; d < ND; d++)
      check($sformatf("d%0d words popped", d), rd_ptr[d], exp_idx[d]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
